// File: rtl/gpr_bank_scheduler_pkg.sv
// Shared types and constants for the banked GPR read scheduler.
// Holds the bank width, the response tag layout and the per-slot state codes.
package gpr_bank_scheduler_pkg;

  localparam int GPR_BANK_BITS    = 2;
  localparam int GPR_SRC_BITS     = 2;
  localparam int GPR_TAG_REQ_BITS = 4;

  // The tag carries a generously sized slot field; the top exports only the low REQ_BITS.
  typedef struct packed {
    logic [GPR_TAG_REQ_BITS-1:0] req_idx;
    logic [GPR_SRC_BITS-1:0]     src_idx;
  } gpr_sched_tag_t;

  typedef logic [1:0] slot_state_t;

  localparam slot_state_t SLOT_IDLE  = 2'd0;
  localparam slot_state_t SLOT_FETCH = 2'd1;
  localparam slot_state_t SLOT_DRAIN = 2'd2;
  localparam slot_state_t SLOT_DONE  = 2'd3;

  function automatic int log2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpr_bank_scheduler_arb_slice.sv
// One bank's arbiter: picks a slot round-robin from rr_ptr, then that slot's
// lowest-numbered pending source; the pointer advances past the winner.
module gpr_bank_arb_slice
  import gpr_bank_scheduler_pkg::*;
#(
  parameter int NUM_REQS = 2,
  parameter int NUM_SRCS = 3,
  parameter int REQ_BITS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [NUM_REQS*NUM_SRCS-1:0] cand,
  output logic                         gnt_valid,
  output logic [REQ_BITS-1:0]          gnt_req,
  output logic [GPR_SRC_BITS-1:0]      gnt_src
);

  logic [REQ_BITS-1:0] rr_ptr;

  // Distance from the pointer ranks slots, so no dynamic rotation is needed.
  always_comb begin
    int d;
    int best;
    d       = 0;
    best    = NUM_REQS;
    gnt_req = '0;
    gnt_src = '0;
    for (int s = 0; s < NUM_REQS; s++) begin
      d = s - int'(rr_ptr);
      if (d < 0) d = d + NUM_REQS;
      if ((|cand[s*NUM_SRCS +: NUM_SRCS]) && (d < best)) begin
        best    = d;
        gnt_req = REQ_BITS'(s);
        gnt_src = '0;
        for (int j = NUM_SRCS - 1; j >= 0; j--)
          if (cand[s*NUM_SRCS + j]) gnt_src = GPR_SRC_BITS'(j);
      end
    end
    gnt_valid = !stall && (best < NUM_REQS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (gnt_valid)
      rr_ptr <= (int'(gnt_req) == NUM_REQS - 1) ? '0 : gnt_req + 1'b1;
  end

endmodule

// File: rtl/gpr_bank_scheduler.sv
// Banked GPR read scheduler: per-slot operand FSMs, one arbiter per bank and a
// one-cycle response tag pipeline matching the RAM read latency.
module gpr_bank_scheduler
  import gpr_bank_scheduler_pkg::*;
#(
  parameter int NUM_REQS      = 2,
  parameter int NUM_BANKS     = 4,
  parameter int NUM_SRCS      = 3,
  parameter int NR_BITS       = 6,
  parameter int WIS_BITS      = 2,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQS-1:0]                    req_valid,
  output logic [NUM_REQS-1:0]                    req_ready,
  input  logic [NUM_REQS*WIS_BITS-1:0]           req_wis,
  input  logic [NUM_REQS*NUM_SRCS*NR_BITS-1:0]   req_srcs,
  output logic [NUM_REQS-1:0]                    req_done,
  input  logic                                   bank_rd_stall,
  output logic [NUM_BANKS-1:0]                   bank_rd_valid,
  output logic [NUM_BANKS*(NR_BITS-$clog2(NUM_BANKS)+WIS_BITS)-1:0] bank_rd_addr,
  output logic [NUM_BANKS-1:0]                   rsp_valid,
  output logic [NUM_BANKS*log2_min1(NUM_REQS)-1:0] rsp_req_idx,
  output logic [NUM_BANKS*GPR_SRC_BITS-1:0]      rsp_src_idx,
  output logic [PERF_CTR_BITS-1:0]               perf_conflict_cycles
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ADDRW     = NR_BITS - BANK_BITS + WIS_BITS;
  localparam int REQ_BITS  = log2_min1(NUM_REQS);

  slot_state_t          state   [NUM_REQS];
  logic [NUM_SRCS-1:0]  pending [NUM_REQS];
  logic [NUM_SRCS-1:0]  src_nz  [NUM_REQS];
  logic [NUM_SRCS-1:0]  granted [NUM_REQS];
  logic [NUM_SRCS-1:0]  remain  [NUM_REQS];
  logic [WIS_BITS-1:0]  wis_q   [NUM_REQS];
  logic [NR_BITS-1:0]   srcs_q  [NUM_REQS][NUM_SRCS];

  logic [NUM_REQS*NUM_SRCS-1:0] cand      [NUM_BANKS];
  logic [NUM_BANKS-1:0]         gnt_valid;
  logic [REQ_BITS-1:0]          gnt_req   [NUM_BANKS];
  logic [GPR_SRC_BITS-1:0]      gnt_src   [NUM_BANKS];
  gpr_sched_tag_t               issue_tag [NUM_BANKS];
  gpr_sched_tag_t               rsp_tag_p1 [NUM_BANKS];
  logic [NUM_BANKS-1:0]         rsp_vld_p1;
  logic                         conflict;

  always_comb begin
    for (int s = 0; s < NUM_REQS; s++)
      for (int j = 0; j < NUM_SRCS; j++)
        src_nz[s][j] = |req_srcs[(s*NUM_SRCS + j)*NR_BITS +: NR_BITS];
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      cand[b] = '0;
      for (int s = 0; s < NUM_REQS; s++)
        for (int j = 0; j < NUM_SRCS; j++)
          cand[b][s*NUM_SRCS + j] = (state[s] == SLOT_FETCH) && pending[s][j] &&
                                    (srcs_q[s][j][BANK_BITS-1:0] == BANK_BITS'(b));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    gpr_bank_arb_slice #(
      .NUM_REQS (NUM_REQS),
      .NUM_SRCS (NUM_SRCS),
      .REQ_BITS (REQ_BITS)
    ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .stall     (bank_rd_stall),
      .cand      (cand[b]),
      .gnt_valid (gnt_valid[b]),
      .gnt_req   (gnt_req[b]),
      .gnt_src   (gnt_src[b])
    );
  end

  // Fold the per-bank grants back onto the slots; a stall yields no grants.
  always_comb begin
    conflict = 1'b0;
    for (int s = 0; s < NUM_REQS; s++) granted[s] = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int s = 0; s < NUM_REQS; s++)
        for (int j = 0; j < NUM_SRCS; j++)
          if (gnt_valid[b] && (int'(gnt_req[b]) == s) && (int'(gnt_src[b]) == j))
            granted[s][j] = 1'b1;
    for (int s = 0; s < NUM_REQS; s++) begin
      remain[s] = pending[s] & ~granted[s];
      if ((state[s] == SLOT_FETCH) && (|remain[s]) && !bank_rd_stall) conflict = 1'b1;
    end
  end

  always_comb begin
    bank_rd_valid = gnt_valid;
    bank_rd_addr  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      issue_tag[b] = '0;
      if (gnt_valid[b]) begin
        bank_rd_addr[b*ADDRW +: ADDRW] = {srcs_q[gnt_req[b]][gnt_src[b]][NR_BITS-1:BANK_BITS],
                                          wis_q[gnt_req[b]]};
        issue_tag[b].req_idx = GPR_TAG_REQ_BITS'(gnt_req[b]);
        issue_tag[b].src_idx = gnt_src[b];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_REQS; s++) begin
      req_ready[s] = (state[s] == SLOT_IDLE);
      req_done[s]  = (state[s] == SLOT_DRAIN) || (state[s] == SLOT_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_REQS; s++) begin
        state[s]   <= SLOT_IDLE;
        pending[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_REQS; s++) begin
        case (state[s])
          SLOT_IDLE: if (req_valid[s]) begin
            pending[s] <= src_nz[s];
            state[s]   <= (|src_nz[s]) ? SLOT_FETCH : SLOT_DONE;
          end
          SLOT_FETCH: if (!bank_rd_stall) begin
            pending[s] <= remain[s];
            if (remain[s] == '0) state[s] <= SLOT_DRAIN;
          end
          default: state[s] <= SLOT_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_REQS; s++) begin
      if ((state[s] == SLOT_IDLE) && req_valid[s]) begin
        wis_q[s] <= req_wis[s*WIS_BITS +: WIS_BITS];
        for (int j = 0; j < NUM_SRCS; j++)
          srcs_q[s][j] <= req_srcs[(s*NUM_SRCS + j)*NR_BITS +: NR_BITS];
      end
    end
  end

  // Stage p1: tags follow the reads by one cycle, matching the RAM latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_p1 <= '0;
      for (int b = 0; b < NUM_BANKS; b++) rsp_tag_p1[b] <= '0;
    end else begin
      rsp_vld_p1 <= gnt_valid;
      for (int b = 0; b < NUM_BANKS; b++) rsp_tag_p1[b] <= issue_tag[b];
    end
  end

  always_comb begin
    rsp_valid = rsp_vld_p1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rsp_req_idx[b*REQ_BITS +: REQ_BITS]         = rsp_tag_p1[b].req_idx[REQ_BITS-1:0];
      rsp_src_idx[b*GPR_SRC_BITS +: GPR_SRC_BITS] = rsp_tag_p1[b].src_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      perf_conflict_cycles <= '0;
    else if (conflict && (perf_conflict_cycles != '1))
      perf_conflict_cycles <= perf_conflict_cycles + 1'b1;
  end

endmodule

// File: tb/tb_gpr_bank_scheduler.sv
// Bench for gpr_bank_scheduler: directed vector table, hand sequences and random
// traffic, all compared cycle by cycle against a cycle-count based operand model.
module tb_gpr_bank_scheduler;

  localparam int NR = 2, NB = 4, NS = 3, NRB = 6, WB = 2, PB = 44, ADDRW = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      req_valid, req_ready, req_done;
  logic [NR*WB-1:0]   req_wis;
  logic [NR*NS*NRB-1:0] req_srcs;
  logic               bank_rd_stall;
  logic [NB-1:0]      bank_rd_valid, rsp_valid;
  logic [NB*ADDRW-1:0] bank_rd_addr;
  logic [NB-1:0]      rsp_req_idx;
  logic [NB*2-1:0]    rsp_src_idx;
  logic [PB-1:0]      perf_conflict_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpr_bank_scheduler dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_wis              (req_wis),
    .req_srcs             (req_srcs),
    .req_done             (req_done),
    .bank_rd_stall        (bank_rd_stall),
    .bank_rd_valid        (bank_rd_valid),
    .bank_rd_addr         (bank_rd_addr),
    .rsp_valid            (rsp_valid),
    .rsp_req_idx          (rsp_req_idx),
    .rsp_src_idx          (rsp_src_idx),
    .perf_conflict_cycles (perf_conflict_cycles)
  );

  // Model: a slot is busy from accept until its done cycle; operands may issue
  // from the cycle after accept; done lands the cycle after the last issue.
  bit          m_active   [NR];
  int          m_issue_from [NR];
  int          m_done_at  [NR];
  bit [NS-1:0] m_left     [NR];
  int          m_src      [NR][NS];
  int          m_wis      [NR];
  int          m_rr       [NB];
  bit          e_rv       [NB];
  int          e_rs       [NB];
  int          e_rj       [NB];
  longint      m_perf;
  int          cyc;
  int          obs_done   [NR];
  int          done_cnt   [NR];

  logic [NR*NS*NRB-1:0] drv_srcs;
  logic [NR*WB-1:0]     drv_wis;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NR; s++) begin
      m_active[s] = 0; m_issue_from[s] = 0; m_done_at[s] = -1; m_left[s] = '0;
      m_wis[s] = 0;
      for (int j = 0; j < NS; j++) m_src[s][j] = 0;
    end
    for (int b = 0; b < NB; b++) begin
      m_rr[b] = 0; e_rv[b] = 0; e_rs[b] = 0; e_rj[b] = 0;
    end
    m_perf = 0;
  endtask

  task automatic set_slot(input int sl, input int a, input int b, input int c, input int w);
    drv_srcs[(sl*NS+0)*NRB +: NRB] = NRB'(a);
    drv_srcs[(sl*NS+1)*NRB +: NRB] = NRB'(b);
    drv_srcs[(sl*NS+2)*NRB +: NRB] = NRB'(c);
    drv_wis[sl*WB +: WB]           = WB'(w);
  endtask

  task automatic step(input logic [NR-1:0] v, input logic st);
    bit g_v [NB];
    int g_s [NB];
    int g_j [NB];
    bit conflict, hit;
    bit rdy_snap [NR];
    bit had [NR];
    logic [NB-1:0] e_rd, e_rsp;
    logic [NR-1:0] e_done, e_rdy;
    int s;
    @(negedge clk);
    req_valid = v; bank_rd_stall = st; req_srcs = drv_srcs; req_wis = drv_wis;
    #1;
    e_rd = '0;
    for (int b = 0; b < NB; b++) begin
      g_v[b] = 0; g_s[b] = 0; g_j[b] = 0;
      if (!st) begin
        for (int k = 0; k < NR; k++) begin
          s = (m_rr[b] + k) % NR;
          if (m_active[s] && cyc >= m_issue_from[s])
            for (int j = 0; j < NS; j++)
              if (!g_v[b] && m_left[s][j] && (m_src[s][j] % NB == b)) begin
                g_v[b] = 1; g_s[b] = s; g_j[b] = j;
              end
        end
      end
      e_rd[b] = g_v[b];
    end
    conflict = 0;
    if (!st)
      for (int sl = 0; sl < NR; sl++)
        for (int j = 0; j < NS; j++)
          if (m_active[sl] && cyc >= m_issue_from[sl] && m_left[sl][j]) begin
            hit = 0;
            for (int b = 0; b < NB; b++) if (g_v[b] && g_s[b] == sl && g_j[b] == j) hit = 1;
            if (!hit) conflict = 1;
          end
    for (int b = 0; b < NB; b++) e_rsp[b] = e_rv[b];
    for (int sl = 0; sl < NR; sl++) begin
      e_done[sl] = m_active[sl] && (m_done_at[sl] == cyc);
      e_rdy[sl]  = !m_active[sl];
    end

    chk("rd_valid", 64'(bank_rd_valid), 64'(e_rd));
    for (int b = 0; b < NB; b++)
      if (g_v[b]) chk("rd_addr", 64'(bank_rd_addr[b*ADDRW +: ADDRW]),
                      64'((m_src[g_s[b]][g_j[b]] / NB) * 4 + m_wis[g_s[b]]));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    for (int b = 0; b < NB; b++)
      if (e_rv[b]) begin
        chk("rsp_req_idx", 64'(rsp_req_idx[b]), 64'(e_rs[b]));
        chk("rsp_src_idx", 64'(rsp_src_idx[b*2 +: 2]), 64'(e_rj[b]));
      end
    chk("req_done", 64'(req_done), 64'(e_done));
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("perf", 64'(perf_conflict_cycles), 64'(m_perf));
    for (int sl = 0; sl < NR; sl++)
      if (req_done[sl] === 1'b1) begin obs_done[sl] = cyc; done_cnt[sl]++; end

    for (int sl = 0; sl < NR; sl++) begin
      rdy_snap[sl] = !m_active[sl];
      had[sl] = m_active[sl] && (m_left[sl] != '0);
    end
    for (int b = 0; b < NB; b++) begin
      e_rv[b] = g_v[b]; e_rs[b] = g_s[b]; e_rj[b] = g_j[b];
      if (g_v[b]) begin
        m_left[g_s[b]][g_j[b]] = 1'b0;
        m_rr[b] = (g_s[b] + 1) % NR;
      end
    end
    if (conflict && m_perf < ((64'sd1 <<< PB) - 1)) m_perf++;
    for (int sl = 0; sl < NR; sl++) begin
      if (m_active[sl] && m_done_at[sl] == cyc) m_active[sl] = 0;
      else if (had[sl] && m_left[sl] == '0) m_done_at[sl] = cyc + 1;
      if (rdy_snap[sl] && v[sl]) begin
        m_active[sl] = 1;
        m_wis[sl] = int'(req_wis[sl*WB +: WB]);
        for (int j = 0; j < NS; j++) begin
          m_src[sl][j] = int'(req_srcs[(sl*NS+j)*NRB +: NRB]);
          m_left[sl][j] = (m_src[sl][j] != 0);
        end
        m_issue_from[sl] = cyc + 1;
        m_done_at[sl] = (m_left[sl] == '0) ? cyc + 1 : -1;
      end
    end
    cyc++;
  endtask

  typedef struct {
    logic [NR-1:0] v;
    int a0, b0, c0, a1, b1, c1;
    logic [7:0] stall;
    int lat0, lat1, perf;
  } vec_t;

  function automatic vec_t mk(input logic [NR-1:0] v, input int a0, input int b0, input int c0,
                              input int a1, input int b1, input int c1, input logic [7:0] st,
                              input int l0, input int l1, input int p);
    vec_t e;
    e.v = v; e.a0 = a0; e.b0 = b0; e.c0 = c0; e.a1 = a1; e.b1 = b1; e.c1 = c1;
    e.stall = st; e.lat0 = l0; e.lat1 = l1; e.perf = p;
    return e;
  endfunction

  task automatic run_entry(input vec_t e, input int idx);
    int t0, guard;
    logic [PB-1:0] p0;
    guard = 0;
    while ((m_active[0] || m_active[1]) && guard < 30) begin step('0, 1'b0); guard++; end
    chk("ready_wait", 64'(guard < 30), 64'd1);
    set_slot(0, e.a0, e.b0, e.c0, idx % 4);
    set_slot(1, e.a1, e.b1, e.c1, (idx + 1) % 4);
    p0 = perf_conflict_cycles;
    obs_done[0] = -1; obs_done[1] = -1;
    t0 = cyc;
    for (int k = 0; k < 25; k++) begin
      step((k == 0) ? e.v : '0, (k < 8) ? e.stall[k] : 1'b0);
      if ((!e.v[0] || obs_done[0] >= 0) && (!e.v[1] || obs_done[1] >= 0)) break;
    end
    step('0, 1'b0);
    if (e.v[0]) chk($sformatf("vec%0d_lat0", idx), 64'(obs_done[0] - t0), 64'(e.lat0));
    if (e.v[1]) chk($sformatf("vec%0d_lat1", idx), 64'(obs_done[1] - t0), 64'(e.lat1));
    chk($sformatf("vec%0d_perf", idx), 64'(perf_conflict_cycles - p0), 64'(e.perf));
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
  endfunction

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1; req_valid = '0; bank_rd_stall = 1'b0; req_srcs = '0; req_wis = '0;
    drv_srcs = '0; drv_wis = '0; cyc = 0;
    for (int s = 0; s < NR; s++) begin obs_done[s] = -1; done_cnt[s] = 0; end
    model_reset();
    #1 reset = 1'b0;
    #2;
    chk("rst_rd_valid", 64'(bank_rd_valid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_done", 64'(req_done), 64'd0);
    chk("rst_perf", 64'(perf_conflict_cycles), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    chk("rst_req_ready", 64'(req_ready), 64'h3);

    //             v      s0          s1          stall        lat0 lat1 perf
    tbl[0]  = mk(2'b01, 1, 2, 3,    0, 0, 0,    8'b0000_0000, 2, 0, 0);
    tbl[1]  = mk(2'b11, 1, 0, 0,    5, 0, 0,    8'b0000_0000, 3, 2, 1);
    tbl[2]  = mk(2'b10, 0, 0, 0,    13, 0, 0,   8'b0000_0000, 0, 2, 0);
    tbl[3]  = mk(2'b11, 1, 0, 0,    5, 0, 0,    8'b0000_0000, 2, 3, 1);
    tbl[4]  = mk(2'b01, 1, 5, 9,    0, 0, 0,    8'b0000_0000, 4, 0, 2);
    tbl[5]  = mk(2'b01, 0, 0, 0,    0, 0, 0,    8'b0000_0000, 1, 0, 0);
    tbl[6]  = mk(2'b11, 2, 6, 0,    3, 7, 4,    8'b0000_0000, 3, 3, 1);
    tbl[7]  = mk(2'b11, 0, 0, 0,    0, 0, 0,    8'b0000_0000, 1, 1, 0);
    tbl[8]  = mk(2'b01, 63, 62, 61, 0, 0, 0,    8'b0000_0000, 2, 0, 0);
    tbl[9]  = mk(2'b01, 1, 5, 0,    0, 0, 0,    8'b0000_1110, 6, 0, 1);
    tbl[10] = mk(2'b01, 1, 5, 9,    0, 0, 0,    8'b0001_1100, 7, 0, 2);
    tbl[11] = mk(2'b01, 2, 0, 0,    0, 0, 0,    8'b0000_0001, 2, 0, 0);
    tbl[12] = mk(2'b10, 0, 0, 0,    6, 6, 0,    8'b0000_0000, 0, 3, 1);
    for (int i = 0; i < 13; i++) run_entry(tbl[i], i);

    // Back-to-back empty instructions: accept, done, re-accept the cycle after.
    set_slot(0, 0, 0, 0, 1);
    d0 = done_cnt[0];
    for (int k = 0; k < 6; k++) step(2'b01, 1'b0);
    chk("b2b_done_pulses", 64'(done_cnt[0] - d0), 64'd3);
    step('0, 1'b0);

    // Asynchronous reset while slot 0 is mid-FETCH with a response in flight.
    set_slot(0, 1, 5, 9, 2);
    step(2'b01, 1'b0);
    step('0, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_rd_valid", 64'(bank_rd_valid), 64'd0);
    chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_req_done", 64'(req_done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'h3);
    chk("post_rst_perf", 64'(perf_conflict_cycles), 64'd0);
    step('0, 1'b0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      for (int s = 0; s < NR; s++)
        set_slot(s, rnd_reg(), rnd_reg(), rnd_reg(), int'($urandom_range(0, 3)));
      step(NR'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
    end
    for (int k = 0; k < 20; k++) step('0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_bank_scheduler.md
Name: gpr_bank_scheduler

Overview:
- Sequences banked GPR reads on behalf of NUM_REQS operand-collector slots.
- Each slot hands over one instruction's source-register set. The scheduler issues per-bank read requests over one or more cycles, serializing bank conflicts and round-robin sharing banks between slots.
- Each response is tagged with slot and source index, and req_done is signalled once all of a slot's operands have returned.
- Sits between the scoreboard/collector slots and the per-bank dual-port GPR RAMs; the write port stays with writeback.

Parameters:
- NUM_REQS, 2, number of collector slots sharing the banks.
- NUM_BANKS, 4, GPR banks; power of two; bank = rs[BANK_BITS-1:0].
- NUM_SRCS, 3, source operands per instruction.
- NR_BITS, 6, register-number width; register 0 is never read.
- WIS_BITS, 2, issue-warp index width.
- PERF_CTR_BITS, 44, perf counter width.
- Derived: BANK_BITS = log2(NUM_BANKS); ADDRW = NR_BITS - BANK_BITS + WIS_BITS; REQ_BITS = max(1, log2(NUM_REQS)); SRC_BITS = 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQS  slot presents instruction.
- req_ready  out  NUM_REQS  slot idle, accepts instruction.
- req_wis  in  NUM_REQS*WIS_BITS  issue-warp index.
- req_srcs  in  NUM_REQS*NUM_SRCS*NR_BITS  source register numbers.
- req_done  out  NUM_REQS  one-cycle pulse: all operands of slot returned.
- bank_rd_stall  in  1  blocks new read issue.
- bank_rd_valid  out  NUM_BANKS  read enable per bank.
- bank_rd_addr  out  NUM_BANKS*ADDRW  {rs[NR_BITS-1:BANK_BITS], wis}.
- rsp_valid  out  NUM_BANKS  bank read data valid this cycle (RAM latency 1).
- rsp_req_idx  out  NUM_BANKS*REQ_BITS  owning slot of response.
- rsp_src_idx  out  NUM_BANKS*SRC_BITS  operand index (0=rs1..2=rs3).
- perf_conflict_cycles  out  PERF_CTR_BITS  conflict-stall counter.

Behaviour:
- Reset (reset low, async): all slots IDLE; pending masks 0; round-robin pointers 0; every output 0 except req_ready (all 1 after reset release); counter 0.

Per-slot FSM:
- IDLE:
  - req_ready=1.
  - On req_valid: latch wis and srcs; pending[s] = (srcs[s] != 0).
  - If pending == 0, go to DONE; else go to FETCH.
- FETCH:
  - Each unstalled cycle, granted operands clear their pending bits and record an in-flight tag.
  - When pending becomes 0 (including the grant cycle), go to DRAIN next cycle.
- DRAIN: the last issued reads return this cycle (rsp_valid). Assert req_done and go to IDLE.
- DONE (empty-mask path): assert req_done for 1 cycle, go to IDLE.
- req_ready = (state == IDLE); a new accept is possible the cycle after req_done.
- Minimum latency: accept at T; issue at T+1; rsp and req_done at T+2.

Arbitration (per bank, per cycle, bank_rd_stall=0):
- Candidates are all FETCH slots with any pending operand mapped to this bank.
- Slot choice is round-robin starting at rr_ptr[bank]. Within a slot, the lowest source index wins.
- rr_ptr[bank] moves to granted slot+1 (mod NUM_REQS) on grant; otherwise unchanged.
- Duplicate registers within an instruction (e.g. rs1==rs2) are read separately, same bank, serialized.
- Each slot can receive grants from several banks in one cycle (one per bank).

Response path:
- Tag {slot, src} is registered alongside bank_rd_valid. rsp_* equal the issue-cycle values delayed by exactly 1 cycle.
- Responses always emerge, even if bank_rd_stall is asserted in the response cycle.

Stall:
- bank_rd_stall=1 gives bank_rd_valid=0 and freezes pending masks and rr pointers.
- Accepts in IDLE, DRAIN completion and DONE still proceed.

perf_conflict_cycles:
- +1 per cycle with bank_rd_stall=0 where any FETCH slot holds a pending bit that was not granted.
- Saturates at all-ones.

Outputs bank_rd_* and rsp_* are combinational from registered state/arbiter, except rsp_* which are registered.

Decomposition:
- VX_gpu_pkg additions: GPR_BANK_BITS, gpr_sched_tag_t {req_idx, src_idx}, slot state enum {IDLE, FETCH, DRAIN, DONE}.
- One sub-module, gpr_bank_arb_slice: one bank's request gather, round-robin slot select, in-slot priority select, pointer register. Instantiated NUM_BANKS times.
- Slot FSMs and the response pipeline stay in the top level.

Test Plan:
- Slot0 srcs {1,2,3}, banks 1,2,3 distinct: accept T0 -> bank1/2/3 rd_valid at T1 with addrs {0,wis}; rsp tags (0,0),(0,1),(0,2) and req_done[0] at T2.
- Slot0 srcs {1,5,9}, all bank 1: three reads T1,T2,T3 in src order 0,1,2; req_done[0] at T4; perf counter +2.
- Slot0 {1,0,0} and slot1 {5,0,0} accepted same cycle, both bank 1: slot0 granted T1, slot1 T2. Repeat with rr_ptr=1: slot1 first.
- Slot srcs {0,0,0} -> no bank_rd_valid; req_done pulses the cycle after accept; req_ready returns next cycle.
- bank_rd_stall held high T1..T3 on a 2-conflict instruction: no rd_valid during stall, reads resume T4,T5; in-flight rsp at stall onset still appears.
- Assert reset low mid-FETCH: all rd_valid, rsp_valid and req_done drop immediately (async); after release req_ready=all 1 and the counter reads 0.
